vec_mem_seq: RTL and testbench

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

---
 rtl/vec_mem_seq.sv | 146 ++++++++++++++
 tb/tb_vec_mem_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: sequences the memory accesses of one vector or scalar load/store
// instruction. A vector op issues LANES element requests; a scalar op issues one
// request on lane 0. The downstream pipeline is stalled while requests are in
// flight.
//
// Build option: define VEC_MEM_SEQ_STRIDE_EN to add the stride port. The address
// then advances by the latched stride per element. Without the macro, the address
// advances by 1.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   start      decoded memory instruction present in execute stage
//   mem_op     00 none, 01 vector, 10/11 scalar
//   mem_st     1 = store, 0 = load
//   base_addr  first element address, sampled when the sequence is accepted
//   stride     per-element address increment (VEC_MEM_SEQ_STRIDE_EN only)
//   abort      pipeline flush, cancels the active sequence
//   mem_gnt    memory accepted the current request
//   mem_req    request valid
//   mem_we     write enable for the current request
//   mem_addr   current element address
//   lane_sel   current element index
//   pipe_en    downstream pipeline enable, 0 = stall
//   busy       sequence in progress
//   done       one-cycle completion pulse
module vec_mem_seq #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 mem_op,
    input  logic                       mem_st,
    input  logic [ADDR_W-1:0]          base_addr,
`ifdef VEC_MEM_SEQ_STRIDE_EN
    input  logic [ADDR_W-1:0]          stride,
`endif
    input  logic                       abort,
    input  logic                       mem_gnt,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [$clog2(LANES)-1:0]   lane_sel,
    output logic                       pipe_en,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned LW = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t            state;
    logic [LW-1:0]     last_lane;   // index of the final element of this sequence
    logic [ADDR_W-1:0] addr_inc;
    logic              accept;

`ifdef VEC_MEM_SEQ_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
`endif

    // abort in IDLE wins over start, so a flushed instruction is never accepted
    always_comb begin
        accept  = (state == IDLE) && start && (mem_op != 2'b00) && !abort;
        pipe_en = !(accept || (state == ISSUE));
    end

    always_comb begin
`ifdef VEC_MEM_SEQ_STRIDE_EN
        addr_inc = stride_q;
`else
        addr_inc = ADDR_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_lane <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            lane_sel  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
            stride_q  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ISSUE;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_st;
                        mem_addr  <= base_addr;
                        lane_sel  <= '0;
                        last_lane <= (mem_op == 2'b01) ? LW'(LANES - 1) : '0;
                        busy      <= 1'b1;
`ifdef VEC_MEM_SEQ_STRIDE_EN
                        stride_q  <= stride;
`endif
                    end
                end
                ISSUE: begin
                    // abort outranks a simultaneous grant; the granted element
                    // is still considered performed by memory
                    if (abort) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (mem_gnt) begin
                        if (lane_sel == last_lane) begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            lane_sel <= lane_sel + 1'b1;
                            mem_addr <= mem_addr + addr_inc;  // wraps modulo 2^ADDR_W
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
module tb_vec_mem_seq;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned LW     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mem_op;
    logic              mem_st;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic              abort;
    logic              mem_gnt;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LW-1:0]     lane_sel;
    logic              pipe_en;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LW-1:0]     lane;
        logic              we;
    } req_t;

    req_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    always #5 clk = ~clk;

    vec_mem_seq #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_op    (mem_op),
        .mem_st    (mem_st),
        .base_addr (base_addr),
`ifdef VEC_MEM_SEQ_STRIDE_EN
        .stride    (stride),
`endif
        .abort     (abort),
        .mem_gnt   (mem_gnt),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .lane_sel  (lane_sel),
        .pipe_en   (pipe_en),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] inc_of(input logic [ADDR_W-1:0] s);
`ifdef VEC_MEM_SEQ_STRIDE_EN
        return s;
`else
        return (s & '0) | ADDR_W'(1);
`endif
    endfunction

    // push the expected element requests of a sequence
    task automatic push_seq(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] s,
                            input int n, input logic st);
        logic [ADDR_W-1:0] a;
        req_t r;
        a = base;
        for (int i = 0; i < n; i++) begin
            r.addr = a;
            r.lane = LW'(i);
            r.we   = st;
            sb.push_back(r);
            a = a + inc_of(s);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},  mem_req,  0);
        chk({tag, "_we"},   mem_we,   0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_lane"}, lane_sel, 0);
        chk({tag, "_busy"}, busy,     0);
        chk({tag, "_done"}, done,     0);
        chk({tag, "_pipe"}, pipe_en,  1);
    endtask

    // full sequence with mem_gnt held high; called right after step()
    task automatic run_seq(input logic [1:0] op, input logic st, input logic [ADDR_W-1:0] base,
                           input logic [ADDR_W-1:0] s, input int n);
        start = 1'b1; mem_op = op; mem_st = st; base_addr = base; stride = s; mem_gnt = 1'b1;
        push_seq(base, s, n, st);
        @(negedge clk);
        chk("accept_pipe", pipe_en, 0);
        chk("accept_req", mem_req, 0);
        step();
        start = 1'b0; mem_op = 2'b00;
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            chk("seq_req",  mem_req, (c <= n) ? 1 : 0);
            chk("seq_we",   mem_we,  (c <= n) ? 32'(st) : 0);
            chk("seq_busy", busy,    (c <= n + 1) ? 1 : 0);
            chk("seq_done", done,    (c == n + 1) ? 1 : 0);
            chk("seq_pipe", pipe_en, (c > n) ? 1 : 0);
            step();
        end
        exp_done++;
    endtask

    // scoreboard: each granted request is compared against the oldest expectation
    always @(negedge clk) begin
        req_t item;
        if (done === 1'b1) done_cnt++;
        if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_req observed=%0h expected=none", mem_addr);
            end
            if (sb.size() != 0) begin
                item = sb.pop_front();
                chk("req_addr", mem_addr, item.addr);
                chk("req_lane", lane_sel, item.lane);
                chk("req_we",   mem_we,   item.we);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; mem_op = 2'b00; mem_st = 1'b0;
        base_addr = '0; stride = '0; abort = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        step();
        reset = 1'b1;
        step();

        // vector load, unit stride
        run_seq(2'b01, 1'b0, 18'h00100, 18'h1, 4);

        // vector store wrapping past the top of the address space
        step();
        run_seq(2'b01, 1'b1, 18'h3FFFE, 18'h1, 4);

        // strided vector load (unit increments in the default build)
        step();
        run_seq(2'b01, 1'b0, 18'h00010, 18'h4, 4);

        // scalar op 11 is a single lane-0 access
        step();
        run_seq(2'b11, 1'b1, 18'h00777, 18'h4, 1);

        // scalar op 10 with grant delayed three cycles; start kept high while busy
        step();
        start = 1'b1; mem_op = 2'b10; mem_st = 1'b0; base_addr = 18'h00020; mem_gnt = 1'b0;
        push_seq(18'h00020, 18'h1, 1, 1'b0);
        @(negedge clk);
        chk("sc_accept_pipe", pipe_en, 0);
        step();
        mem_op = 2'b01; base_addr = 18'h00055;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) mem_gnt = 1'b1;
            @(negedge clk);
            chk("sc_req",  mem_req,  1);
            chk("sc_addr", mem_addr, 18'h00020);
            chk("sc_lane", lane_sel, 0);
            chk("sc_pipe", pipe_en,  0);
            step();
        end
        @(negedge clk);
        chk("sc_done",      done,    1);
        chk("sc_done_pipe", pipe_en, 1);
        chk("sc_done_req",  mem_req, 0);
        step();
        start = 1'b0; mem_op = 2'b00; mem_gnt = 1'b0;
        @(negedge clk);
        chk("sc_idle_busy", busy,    0);
        chk("sc_idle_req",  mem_req, 0);
        exp_done++;
        step();

        // abort on lane 2 together with a grant
        start = 1'b1; mem_op = 2'b01; mem_st = 1'b1; base_addr = 18'h00200; mem_gnt = 1'b1;
        push_seq(18'h00200, 18'h1, 3, 1'b1);
        step();
        start = 1'b0; mem_op = 2'b00;
        step();
        step();
        abort = 1'b1;
        @(negedge clk);
        chk("ab_lane", lane_sel, 2);
        chk("ab_req",  mem_req,  1);
        step();
        abort = 1'b0; mem_gnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ab_busy", busy,    0);
            chk("ab_pipe", pipe_en, 1);
            chk("ab_done", done,    0);
            chk("ab_req",  mem_req, 0);
            chk("ab_we",   mem_we,  0);
            step();
        end

        // abort in IDLE wins over start; mem_op 00 is ignored
        start = 1'b1; mem_op = 2'b01; abort = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        chk("idle_abort_pipe", pipe_en, 1);
        step();
        abort = 1'b0; mem_op = 2'b00;
        @(negedge clk);
        chk("idle_abort_busy", busy,    0);
        chk("op00_pipe",       pipe_en, 1);
        step();
        start = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        chk("op00_busy", busy,    0);
        chk("op00_req",  mem_req, 0);
        step();

        // reset during lane 1
        start = 1'b1; mem_op = 2'b01; mem_st = 1'b1; base_addr = 18'h00300; mem_gnt = 1'b1;
        push_seq(18'h00300, 18'h1, 1, 1'b1);
        step();
        start = 1'b0; mem_op = 2'b00;
        step();
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        reset = 1'b1;
        start = 1'b1; mem_op = 2'b00; base_addr = 18'h00400;
        @(negedge clk);
        chk("post_rst_pipe", pipe_en, 1);
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            chk("post_rst_req",  mem_req, 0);
            chk("post_rst_busy", busy,    0);
        end
        start = 1'b0;
        step();

        chk("sb_empty",   sb.size(), 0);
        chk("done_count", done_cnt,  exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
